counter_bank_rd: RTL and testbench

- Parametrised bank of N_CH independent synchronous event counters.
- Successor to the fixed 32-channel 1-bit toggle-counter array.
- Adds configurable width, a terminal value, and wrap or saturate mode.
- Adds per-channel increment enable and per-channel clear, plus sticky overflow flags.
- Adds an atomic snapshot with serial valid/ready readout, so a slow consumer can read all channels coherently.

---
 rtl/counter_bank_rd.sv | 74 +++++++
 tb/tb_counter_bank_rd.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/counter_bank_rd.sv
// counter_bank_rd: bank of wrap/saturate event counters with sticky overflow and coherent snapshot readout
module counter_bank_rd #(
  parameter int N_CH = 32,
  parameter int WIDTH = 1,
  parameter int MAX = (1 << WIDTH) - 1,
  parameter int SATURATE = 0,
  parameter int IDXW = $clog2(N_CH)
) (
  input  logic                  c,
  input  logic                  r,
  input  logic [N_CH-1:0]       inc,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH*WIDTH-1:0] cnt,
  output logic [N_CH-1:0]       ovf,
  input  logic                  snap_req,
  output logic                  snap_valid,
  input  logic                  snap_ready,
  output logic [IDXW-1:0]       snap_idx,
  output logic [WIDTH-1:0]      snap_data,
  output logic                  snap_busy,
  output logic                  snap_done
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [IDXW-1:0] LAST = IDXW'(N_CH - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0][WIDTH-1:0] cnt_q, cnt_d, shadow_q;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic done_q, done_d, fire, last;
  // per-channel next count: clear wins, then increment with wrap or saturate at MAX
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int k = 0; k < N_CH; k++) begin
      cnt_d[k] = clr[k] ? '0 : !inc[k] ? cnt_q[k] : cnt_q[k] != MAXV ? cnt_q[k] + WIDTH'(1) : (SATURATE != 0) ? MAXV : '0;
      ovf_d[k] = !clr[k] & (ovf_q[k] | (inc[k] & (cnt_q[k] == MAXV)));
    end
  end
  // live counters and sticky overflow flags
  always_ff @(posedge c) begin
    cnt_q <= r ? '0 : cnt_d;
    ovf_q <= r ? '0 : ovf_d;
  end
  // shadow captures pre-update counts when an idle snapshot request is taken
  always_ff @(posedge c) begin
    if (r) shadow_q <= '0;
    else if (state_q == IDLE && snap_req) shadow_q <= cnt_q;
  end
  // readout state register
  always_ff @(posedge c) begin
    state_q <= r ? IDLE : state_d;
    idx_q   <= r ? '0 : idx_d;
    done_q  <= r ? 1'b0 : done_d;
  end
  // readout next state: step index on each accepted word, return to idle after the last
  always_comb begin
    fire    = (state_q == SEND) & snap_ready;
    last    = idx_q == LAST;
    state_d = state_q == IDLE ? (snap_req ? SEND : IDLE) : (fire & last ? IDLE : SEND);
    idx_d   = fire ? (last ? '0 : idx_q + IDXW'(1)) : idx_q;
    done_d  = fire & last;
  end
  // readout outputs
  always_comb begin
    snap_valid = state_q == SEND;
    snap_busy  = state_q == SEND;
    snap_idx   = idx_q;
    snap_data  = snap_valid ? shadow_q[idx_q] : '0;
    snap_done  = done_q;
    cnt        = cnt_q;
    ovf        = ovf_q;
  end
endmodule

// File: tb/tb_counter_bank_rd.sv
// tb_counter_bank_rd: wrap and saturate counter banks checked against a queue-based reference model
module tb_counter_bank_rd;
  localparam int N = 4;
  localparam int W = 4;
  localparam int MX = 9;
  logic c = 1'b0;
  logic r;
  logic [N-1:0] inc, clr;
  logic req, rdy;
  logic [N*W-1:0] cnt_w [2];
  logic [N-1:0] ovf_w [2];
  logic val_w [2];
  logic busy_w [2];
  logic done_w [2];
  logic [1:0] idx_w [2];
  logic [W-1:0] dat_w [2];
  int total = 0;
  int bad = 0;
  int mc [2][N];
  bit mo [2][N];
  int wq [$];
  bit md;
  always #5 c = ~c;
  counter_bank_rd #(.N_CH(N), .WIDTH(W), .MAX(MX), .SATURATE(0)) dut_w (
    .c(c), .r(r), .inc(inc), .clr(clr), .cnt(cnt_w[0]), .ovf(ovf_w[0]),
    .snap_req(req), .snap_valid(val_w[0]), .snap_ready(rdy), .snap_idx(idx_w[0]),
    .snap_data(dat_w[0]), .snap_busy(busy_w[0]), .snap_done(done_w[0]));
  counter_bank_rd #(.N_CH(N), .WIDTH(W), .MAX(MX), .SATURATE(1)) dut_s (
    .c(c), .r(r), .inc(inc), .clr(clr), .cnt(cnt_w[1]), .ovf(ovf_w[1]),
    .snap_req(req), .snap_valid(val_w[1]), .snap_ready(rdy), .snap_idx(idx_w[1]),
    .snap_data(dat_w[1]), .snap_busy(busy_w[1]), .snap_done(done_w[1]));
  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic mclear();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++) begin
        mc[d][k] = 0;
        mo[d][k] = 0;
      end
    wq.delete();
    md = 0;
  endtask
  task automatic check_all();
    int w, v;
    v = wq.size() != 0;
    w = v ? wq[0] : 0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("cnt%0d[%0d]", d, k), 32'(cnt_w[d][k*W +: W]), mc[d][k]);
        chk($sformatf("ovf%0d[%0d]", d, k), 32'(ovf_w[d][k]), int'(mo[d][k]));
      end
      chk($sformatf("valid%0d", d), 32'(val_w[d]), v);
      chk($sformatf("busy%0d", d), 32'(busy_w[d]), v);
      chk($sformatf("idx%0d", d), 32'(idx_w[d]), v ? N - wq.size() : 0);
      chk($sformatf("data%0d", d), 32'(dat_w[d]), d == 1 ? (w >> 8) & 255 : w & 255);
      chk($sformatf("done%0d", d), 32'(done_w[d]), int'(md));
    end
  endtask
  task automatic model_step();
    bit hs, st, nd;
    if (r) begin
      mclear();
      return;
    end
    hs = wq.size() > 0 && rdy;
    st = wq.size() == 0 && req;
    nd = hs && wq.size() == 1;
    if (hs) void'(wq.pop_front());
    if (st)
      for (int k = 0; k < N; k++) wq.push_back(mc[0][k] | (mc[1][k] << 8));
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++)
        if (clr[k]) begin
          mc[d][k] = 0;
          mo[d][k] = 0;
        end else if (inc[k]) begin
          if (mc[d][k] == MX) begin
            mc[d][k] = d == 1 ? MX : 0;
            mo[d][k] = 1;
          end else mc[d][k]++;
        end
    md = nd;
  endtask
  task automatic cyc();
    @(negedge c);
    check_all();
    model_step();
    @(posedge c);
    #1;
  endtask
  initial begin
    r = 1; inc = '0; clr = '0; req = 0; rdy = 0;
    repeat (2) @(posedge c);
    #1;
    mclear();
    cyc();
    r = 0;
    inc = 4'b0011;
    repeat (12) cyc();
    inc = '0;
    chk("wrap_cnt0", 32'(cnt_w[0][3:0]), 2);
    chk("wrap_ovf0", 32'(ovf_w[0][0]), 1);
    chk("sat_cnt1", 32'(cnt_w[1][7:4]), 9);
    chk("sat_ovf1", 32'(ovf_w[1][1]), 1);
    chk("idle_ch23", 32'(cnt_w[0][15:8]), 0);
    clr = 4'b0010;
    cyc();
    clr = '0;
    chk("clr_cnt1", 32'(cnt_w[1][7:4]), 0);
    chk("clr_ovf1", 32'(ovf_w[1][1]), 0);
    inc = 4'b0100;
    repeat (5) cyc();
    chk("pre_cnt2", 32'(cnt_w[0][11:8]), 5);
    clr = 4'b0100;
    cyc();
    clr = '0; inc = '0;
    chk("clr_beats_inc", 32'(cnt_w[0][11:8]), 0);
    chk("clr_beats_inc_ovf", 32'(ovf_w[0][2]), 0);
    r = 1;
    cyc();
    r = 0;
    for (int i = 0; i < 9; i++) begin
      inc = {(i < 9), (i < 0), (i < 7), (i < 3)};
      cyc();
    end
    inc = '0;
    req = 1; rdy = 1;
    cyc();
    req = 0;
    chk("rd_first_idx", 32'(idx_w[0]), 0);
    chk("rd_first_data", 32'(dat_w[0]), 3);
    repeat (5) cyc();
    req = 1;
    cyc();
    req = 0;
    cyc();
    rdy = 0; inc = '1; req = 1;
    repeat (3) cyc();
    chk("stall_idx", 32'(idx_w[0]), 1);
    chk("stall_data", 32'(dat_w[1]), 7);
    inc = '0; req = 0; rdy = 1;
    repeat (5) cyc();
    req = 1;
    cyc();
    req = 0;
    cyc();
    r = 1;
    cyc();
    r = 0;
    chk("abort_valid", 32'(val_w[0]), 0);
    chk("abort_done", 32'(done_w[0]), 0);
    req = 1;
    cyc();
    req = 0;
    chk("restart_idx", 32'(idx_w[1]), 0);
    repeat (6) cyc();
    for (int i = 0; i < 600; i++) begin
      inc = N'($urandom);
      clr = $urandom_range(0, 7) == 0 ? N'($urandom) : '0;
      req = $urandom_range(0, 5) == 0;
      rdy = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 199) == 0;
      cyc();
    end
    r = 0; inc = '0; clr = '0; req = 0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
